// File: rtl/fp_pkg.sv
// Shared floating-point constants, FSM state type and field-slice macros used by
// the adder datapath and the normalise/round stage.
`ifndef FP_PKG_MACROS
`define FP_PKG_MACROS
`define FP_SIGN(v, ew, fw)      v[(ew)+(fw)]
`define FP_EXP(v, ew, fw)       v[(ew)+(fw)-1:(fw)]
`define FP_FRAC(v, fw)          v[(fw)-1:0]
`define MANT_CARRY(m, fw)       m[(fw)+3]
`define MANT_HIDDEN(m, fw)      m[(fw)+2]
`define MANT_FRAC(m, fw)        m[(fw)+1:2]
`define MANT_GUARD(m)           m[1]
`define MANT_STICKY(m)          m[0]
`endif

package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_OVF  = 2;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand, with exponent bump on
// fraction overflow and saturation to infinity.
module fp_round_rne #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [EXP_W+1:0]  exp_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              overflow_o
);
  localparam logic [EXP_W+1:0] EXP_INF = {2'b00, {EXP_W{1'b1}}};

  logic              inc;
  logic [FRAC_W:0]   frac_sum;
  logic [EXP_W+1:0]  exp_adj;

  always_comb begin
    inc        = guard_i & (sticky_i | frac_i[0]);
    frac_sum   = {1'b0, frac_i} + {{FRAC_W{1'b0}}, inc};
    exp_adj    = exp_i + {{(EXP_W+1){1'b0}}, frac_sum[FRAC_W]};
    overflow_o = (exp_adj >= EXP_INF);
    if (overflow_o) begin
      frac_o = '0;
      exp_o  = '1;
    end else begin
      // A carry out of the fraction leaves it all-zero, which is exactly 1.0 x 2^(e+1).
      frac_o = frac_sum[FRAC_W-1:0];
      exp_o  = exp_adj[EXP_W-1:0];
    end
  end
endmodule

// File: rtl/fp_norm_round_seq.sv
// Sequential normalise-and-round stage: one left shift per cycle (or one right
// shift on carry), then RNE rounding into a packed IEEE-754 result.
module fp_norm_round_seq #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W:0]            in_exp,
  input  logic [FRAC_W+3:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_fp,
  output logic [2:0]                out_flags
);
  import fp_pkg::*;

  localparam int MW  = FRAC_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam int FPW = 1 + EXP_W + FRAC_W;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EW2-1:0]   exp_q, exp_d;
  logic [MW-1:0]    mant_q, mant_d;
  logic [FPW-1:0]   fp_q, fp_d;
  logic [2:0]       flags_q, flags_d;

  logic [FRAC_W-1:0] r_frac;
  logic [EXP_W-1:0]  r_exp;
  logic              r_ovf;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .frac_i     (`MANT_FRAC(mant_q, FRAC_W)),
    .exp_i      (exp_q),
    .guard_i    (`MANT_GUARD(mant_q)),
    .sticky_i   (`MANT_STICKY(mant_q)),
    .frac_o     (r_frac),
    .exp_o      (r_exp),
    .overflow_o (r_ovf)
  );

  // NOTE: every register here is a small flop, so all of them take the async
  // reset; output hold values and the working operand are cleared together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      fp_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      fp_q    <= fp_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    fp_d    = fp_q;
    flags_d = flags_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          state_d = NORM;
        end
      end

      NORM: begin
        if (`MANT_CARRY(mant_q, FRAC_W)) begin
          // Right shift by one; the guard bit falls into sticky.
          mant_d  = {1'b0, mant_q[MW-1:2], `MANT_GUARD(mant_q) | `MANT_STICKY(mant_q)};
          exp_d   = exp_q + 1'b1;
          state_d = ROUND;
        end else if (mant_q == '0) begin
          fp_d               = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          flags_d            = '0;
          flags_d[FLAG_ZERO] = 1'b1;
          state_d            = DONE;
        end else if (`MANT_HIDDEN(mant_q, FRAC_W)) begin
          state_d = ROUND;
        end else if (exp_q <= EW2'(1)) begin
          fp_d               = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          flags_d            = '0;
          flags_d[FLAG_ZERO] = 1'b1;
          flags_d[FLAG_UNF]  = 1'b1;
          state_d            = DONE;
        end else begin
          // Left shift hidden/frac/guard; sticky stays put as it summarises bits below guard.
          mant_d = {1'b0, mant_q[MW-3:1], 1'b0, `MANT_STICKY(mant_q)};
          exp_d  = exp_q - 1'b1;
        end
      end

      ROUND: begin
        fp_d              = {sign_q, r_exp, r_frac};
        flags_d           = '0;
        flags_d[FLAG_OVF] = r_ovf;
        state_d           = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_fp    = fp_q;
  assign out_flags = flags_q;
endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Self-checking bench: directed corner cases plus random operands compared
// against an integer-arithmetic reference of normalise + RNE rounding.
module tb_fp_norm_round_seq;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MW     = FRAC_W + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W:0]    in_exp;
  logic [MW-1:0]     in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_fp;
  logic [2:0]        out_flags;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fp_norm_round_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_flags (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: value-level normalisation, then round the 24-bit significand as an integer.
  function automatic void model(input logic s, input int e_in, input logic [MW-1:0] m_in,
                                output logic [31:0] fp, output logic [2:0] fl, output int lat);
    int          e;
    int          shifts;
    logic [63:0] m;
    logic [63:0] sig;
    e      = e_in;
    m      = 64'(m_in);
    shifts = 0;
    fl     = 3'b000;
    fp     = 32'h0;
    lat    = 0;
    if (m[26]) begin
      m   = (m >> 1) | (m & 64'd1);
      e   = e + 1;
      lat = 3;
    end else if (m == 64'd0) begin
      fp  = {s, 31'b0};
      fl  = 3'b001;
      lat = 2;
      return;
    end else begin
      while (m[25] == 1'b0) begin
        if (e <= 1) begin
          fp  = {s, 31'b0};
          fl  = 3'b011;
          lat = shifts + 2;
          return;
        end
        m      = ((m & ~64'd1) << 1) | (m & 64'd1);
        e      = e - 1;
        shifts = shifts + 1;
      end
      lat = shifts + 3;
    end
    sig = m >> 2;
    if (m[1] && (m[0] || sig[0])) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) begin
      fp = {s, 8'hFF, 23'b0};
      fl = 3'b100;
    end else begin
      fp = {s, 8'(e), sig[22:0]};
    end
  endfunction

  task automatic run_op(input logic s, input logic [EXP_W:0] e, input logic [MW-1:0] m,
                        input int hold, input string tag);
    logic [31:0] efp;
    logic [2:0]  efl;
    int          elat;
    int          lat;
    model(s, int'(e), m, efp, efl, elat);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 9'($urandom);
    in_mant  = 27'($urandom);
    lat = 1;
    while (lat < 1000) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".fp"}, out_fp, efp);
    check({tag, ".flags"}, 32'(out_flags), 32'(efl));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, ".hold_fp"}, out_fp, efp);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0]    rm;
    logic [EXP_W:0]   re;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    #12;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_fp", out_fp, 32'h0);
    check("reset.out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 9'd127, 27'h4000000, 0, "carry");
    run_op(1'b0, 9'd127, {2'b01, 23'h400000, 2'b00}, 0, "one_point_five");
    run_op(1'b0, 9'd127, 27'h0100000, 0, "five_shifts");
    run_op(1'b0, 9'd127, {2'b01, {23{1'b1}}, 2'b10}, 0, "round_carry");
    run_op(1'b0, 9'd254, 27'h4000000, 0, "overflow_inf");
    run_op(1'b0, 9'd3, 27'd2, 0, "underflow");
    run_op(1'b1, 9'd127, 27'd0, 0, "neg_zero");
    run_op(1'b0, 9'd127, {2'b01, 23'h000000, 2'b10}, 0, "tie_even_down");
    run_op(1'b1, 9'd130, {2'b01, 23'h2ABCDE, 2'b11}, 5, "hold");

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 9'd127;
    in_mant  = 27'h20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset.out_valid", 32'(out_valid), 32'd0);
    check("midreset.in_ready", 32'(in_ready), 32'd1);
    check("midreset.out_fp", out_fp, 32'h0);
    check("midreset.out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 9'd100, {2'b01, 23'h123456, 2'b01}, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      rm = 27'($urandom) >> $urandom_range(0, 27);
      re = 9'($urandom_range(0, 300));
      run_op(1'($urandom), re, rm, (i % 8 == 0) ? 3 : 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
